// File: rtl/z_modem_tx_pkg.sv
// Shared types and constants for the Z-Modem TX frame scheduler.
// TX_PREAMBLE exists only when TX_PREAMBLE_EN is defined.
package z_modem_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
`ifdef TX_PREAMBLE_EN
        ST_PREAMBLE = 3'd1,
`endif
        ST_PAYLOAD  = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } tx_sched_state_t;

    localparam int SYMS_PER_BLOCK = 64;

    // Covers the load_en cycle itself plus the two cycles after it
    localparam logic [1:0] GUARD_INIT = 2'd3;

`ifdef TX_PREAMBLE_EN
    localparam logic [127:0] TX_PREAMBLE = 128'hAAAA_AAAA_AAAA_AAAA_CCCC_CCCC_3333_3333;
`endif

endpackage

// File: rtl/symbol_tick_gen.sv
// Programmable symbol tick: one-cycle pulse every SYM_DIV enabled clocks.
module symbol_tick_gen #(
    parameter int SYM_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(SYM_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Sequences one TX frame (optional preamble + payload blocks) into the symbol serializer.
// Optional preamble block enabled by defining TX_PREAMBLE_EN.
module tx_frame_scheduler
    import z_modem_tx_pkg::*;
#(
    parameter int SYM_DIV = 100,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [127:0]     blk_data,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic [127:0]     cipher_data,
    output logic             load_en,
    input  logic             buffer_ready,
    output logic             mod_req,
    output logic             busy,
    output logic             done,
    output logic             err_underrun
);

    tx_sched_state_t  state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] blk_cnt;
    logic [1:0]       guard_cnt;
    logic             guard_clr;
    logic             start_acc;
    logic             load_pre;
    logic             load_blk;
    logic             underrun_set;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign guard_clr = (guard_cnt == 2'd0);
    assign start_acc = start && !abort && (state_q == ST_IDLE);

    // A tick with an empty serializer and no block on offer means a symbol slot was lost
    assign underrun_set = (state_q == ST_PAYLOAD) && mod_req && buffer_ready
                          && !blk_valid && guard_clr;

    symbol_tick_gen #(.SYM_DIV(SYM_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .clr   (start_acc || !busy),
        .tick  (mod_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_pre = 1'b0;
        load_blk = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
`ifdef TX_PREAMBLE_EN
                    state_d = ST_PREAMBLE;
`else
                    state_d = (frame_len == '0) ? ST_DRAIN : ST_PAYLOAD;
`endif
                end
            end
`ifdef TX_PREAMBLE_EN
            ST_PREAMBLE: begin
                if (buffer_ready && guard_clr) begin
                    load_pre = 1'b1;
                    state_d  = (len_q == '0) ? ST_DRAIN : ST_PAYLOAD;
                end
            end
`endif
            ST_PAYLOAD: begin
                if (buffer_ready && blk_valid && guard_clr) begin
                    load_blk = 1'b1;
                    if (blk_cnt == len_q - LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (buffer_ready && guard_clr) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            load_pre = 1'b0;
            load_blk = 1'b0;
        end
    end

    // Load strobes, accept pulse and cipher_data all change on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            blk_cnt      <= '0;
            guard_cnt    <= '0;
            cipher_data  <= '0;
            load_en      <= 1'b0;
            blk_ready    <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            load_en   <= load_pre || load_blk;
            blk_ready <= load_blk;
`ifdef TX_PREAMBLE_EN
            if (load_pre) begin
                cipher_data <= TX_PREAMBLE;
            end
`endif
            if (load_blk) begin
                cipher_data <= blk_data;
            end
            if (load_pre || load_blk) begin
                guard_cnt <= GUARD_INIT;
            end else if (!guard_clr) begin
                guard_cnt <= guard_cnt - 2'd1;
            end
            if (start_acc) begin
                len_q        <= frame_len;
                blk_cnt      <= '0;
                err_underrun <= 1'b0;
            end else begin
                if (load_blk) begin
                    blk_cnt <= blk_cnt + LEN_W'(1);
                end
                if (underrun_set) begin
                    err_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a behavioural 64-symbol serializer model.
// Expectations adapt to TX_PREAMBLE_EN when the bench is built with it.
module tb_tx_frame_scheduler;
    import z_modem_tx_pkg::*;

    localparam int SYM_DIV = 10;
    localparam int LEN_W   = 8;
`ifdef TX_PREAMBLE_EN
    localparam int PRE = 1;
`else
    localparam int PRE = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             blk_valid = 1'b0;
    logic             ser_clr = 1'b0;
    logic             mon_clr = 1'b1;
    logic [LEN_W-1:0] frame_len = '0;
    logic [127:0]     blk_data;
    logic [127:0]     cipher_data;
    logic             blk_ready, load_en, buffer_ready, mod_req, busy, done, err_underrun;

    logic [127:0] blk_tab [4] = '{128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                                  128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF,
                                  128'h1111_2222_3333_4444_5555_6666_7777_8888,
                                  128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678};
    logic [127:0] load_data [8];
    logic [127:0] exp_first;

    int sym_left = 0;
    int cyc, start_cyc, first_tick, busy_cnt, load_cnt, rdy_cnt;
    int tick_cnt, tick_at_done, done_cnt, back2back;
    logic prev_load, prev_rdy;
    int n_tests = 0;
    int n_fail  = 0;

    assign blk_data     = blk_tab[rdy_cnt[1:0]];
    assign buffer_ready = (sym_left == 0);

    tx_frame_scheduler #(.SYM_DIV(SYM_DIV), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .frame_len    (frame_len),
        .blk_data     (blk_data),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .cipher_data  (cipher_data),
        .load_en      (load_en),
        .buffer_ready (buffer_ready),
        .mod_req      (mod_req),
        .busy         (busy),
        .done         (done),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    // Serializer: empty when no symbols left; a load refills 64 symbols
    always @(posedge clk) begin
        if (reset || ser_clr)              sym_left <= 0;
        else if (load_en)                  sym_left <= SYMS_PER_BLOCK;
        else if (mod_req && sym_left > 0)  sym_left <= sym_left - 1;
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            cyc = 0; start_cyc = 0; first_tick = 0; busy_cnt = 0; load_cnt = 0;
            rdy_cnt = 0; tick_cnt = 0; tick_at_done = 0; done_cnt = 0; back2back = 0;
            prev_load = 1'b0; prev_rdy = 1'b0;
        end else begin
            cyc++;
            if (start && !busy && !abort) start_cyc = cyc;
            if (busy) busy_cnt++;
            if (load_en) begin
                load_data[load_cnt[2:0]] = cipher_data;
                load_cnt++;
            end
            if ((load_en && prev_load) || (blk_ready && prev_rdy)) back2back++;
            prev_load = load_en;
            prev_rdy  = blk_ready;
            if (blk_ready) rdy_cnt++;
            if (mod_req) begin
                if (tick_cnt == 0) first_tick = cyc;
                tick_cnt++;
            end
            if (done) begin
                done_cnt++;
                tick_at_done = tick_cnt;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk);
        #1;
        frame_len = LEN_W'(len);
        start = 1'b1;
        cyc_wait(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(done_cnt != 0), 128'(1));
        cyc_wait(3);
    endtask

    task automatic wait_rdy(input int budget, input string tag);
        int n = 0;
        while (rdy_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(rdy_cnt != 0), 128'(1));
        cyc_wait(1);
    endtask

    initial begin
        int n;
`ifdef TX_PREAMBLE_EN
        exp_first = TX_PREAMBLE;
`else
        exp_first = blk_tab[0];
`endif
        // Reset state
        cyc_wait(3);
        check("rst_ctrl", 128'({busy, done, load_en, blk_ready, mod_req, err_underrun}), 128'(0));
        check("rst_data", cipher_data, 128'(0));
        reset = 1'b0;
        clear_mon();

        // Normal frame, two blocks, upstream always valid
        blk_valid = 1'b1;
        pulse_start(2);
        check("busy_after_start", 128'(busy), 128'(1));
        wait_done((2 + PRE) * 64 * SYM_DIV + 100, "len2_done");
        check("len2_loads", 128'(load_cnt), 128'(2 + PRE));
        check("len2_ticks", 128'(tick_at_done), 128'(64 * (2 + PRE)));
        check("first_tick_lat", 128'(first_tick - start_cyc), 128'(SYM_DIV));
        check("len2_first_data", load_data[0], exp_first);
        check("len2_blk0", load_data[PRE], blk_tab[0]);
        check("len2_blk1", load_data[PRE + 1], blk_tab[1]);
        check("len2_no_underrun", 128'(err_underrun), 128'(0));
        check("len2_no_back2back", 128'(back2back), 128'(0));
        check("len2_done_once", 128'(done_cnt), 128'(1));
        check("len2_idle", 128'(busy), 128'(0));

        // Zero-length frame
        clear_mon();
        pulse_start(0);
        wait_done(PRE * 64 * SYM_DIV + 100, "len0_done");
        check("len0_loads", 128'(load_cnt), 128'(PRE));
        check("len0_busy_short", 128'(busy_cnt <= (PRE != 0 ? 64 * SYM_DIV + 20 : 3)), 128'(1));
        check("len0_no_ready", 128'(rdy_cnt), 128'(0));

        // Upstream stalls with the serializer empty before block 2
        clear_mon();
        blk_valid = 1'b1;
        pulse_start(2);
        wait_rdy((1 + PRE) * 64 * SYM_DIV + 100, "ur_first_ready");
        blk_valid = 1'b0;
        n = 0;
        while (!buffer_ready && n < 64 * SYM_DIV + 50) begin
            cyc_wait(1);
            n++;
        end
        check("ur_buffer_empty", 128'(buffer_ready), 128'(1));
        cyc_wait(50);
        check("ur_flag_set", 128'(err_underrun), 128'(1));
        check("ur_no_fire", 128'(rdy_cnt), 128'(1));
        blk_valid = 1'b1;
        wait_done(64 * SYM_DIV + 100, "ur_done");
        check("ur_ready_count", 128'(rdy_cnt), 128'(2));
        check("ur_loads", 128'(load_cnt), 128'(2 + PRE));
        check("ur_blk1", load_data[PRE + 1], blk_tab[1]);
        check("ur_sticky", 128'(err_underrun), 128'(1));

        // Second start while busy must not relatch frame_len
        clear_mon();
        pulse_start(1);
        check("err_cleared_by_start", 128'(err_underrun), 128'(0));
        cyc_wait(20);
        pulse_start(5);
        wait_done((1 + PRE) * 64 * SYM_DIV + 100, "relatch_done");
        check("relatch_loads", 128'(load_cnt), 128'(1 + PRE));
        check("relatch_ready", 128'(rdy_cnt), 128'(1));

        // Abort mid-payload, then a clean restart
        clear_mon();
        pulse_start(2);
        wait_rdy((1 + PRE) * 64 * SYM_DIV + 100, "abort_first_ready");
        cyc_wait(100);
        abort = 1'b1;
        cyc_wait(1);
        abort = 1'b0;
        check("abort_outputs", 128'({busy, mod_req, load_en, blk_ready}), 128'(0));
        cyc_wait(20);
        check("abort_no_done", 128'(done_cnt), 128'(0));
        ser_clr = 1'b1;
        cyc_wait(1);
        ser_clr = 1'b0;
        clear_mon();
        pulse_start(2);
        wait_done((2 + PRE) * 64 * SYM_DIV + 100, "restart_done");
        check("restart_loads", 128'(load_cnt), 128'(2 + PRE));
        check("restart_ticks", 128'(tick_at_done), 128'(64 * (2 + PRE)));

        // start and abort together: abort wins
        clear_mon();
        @(posedge clk);
        #1;
        frame_len = LEN_W'(2);
        start = 1'b1;
        abort = 1'b1;
        cyc_wait(1);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 128'(busy), 128'(0));
        cyc_wait(5);
        check("start_abort_no_load", 128'(load_cnt), 128'(0));

        // Reset in the middle of a frame
        clear_mon();
        pulse_start(2);
        cyc_wait(5);
        check("pre_reset_loaded", 128'(load_cnt), 128'(1));
        reset = 1'b1;
        cyc_wait(1);
        check("midrst_ctrl", 128'({busy, done, load_en, blk_ready, mod_req, err_underrun}), 128'(0));
        check("midrst_data", cipher_data, 128'(0));
        reset = 1'b0;
        cyc_wait(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Sequences one transmit frame into `symbol_serializer`. On `start` it:
- optionally loads a fixed preamble block;
- loads `frame_len` 128-bit payload blocks from an upstream cipher stage through a valid/ready handshake;
- paces the serializer with a programmable `mod_req` symbol tick;
- signals `done` once the last symbol has been consumed.

It sits between the cipher core and the serializer/modulator on the Z-Modem TX path.

## Interface
Parameters:
- `SYM_DIV`, 100, clk cycles per symbol tick; legal range 2..65535 (100 = 1 MHz symbols at 100 MHz)
- `LEN_W`, 8, width of `frame_len`

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a frame; ignored while `busy`
- `abort`  in  1  level; forces return to IDLE
- `frame_len`  in  LEN_W  payload block count; latched on accepted `start`
- `blk_data`  in  128  payload block from the cipher stage
- `blk_valid`  in  1  `blk_data` is valid
- `blk_ready`  out  1  block accepted this cycle
- `cipher_data`  out  128  block presented to the serializer
- `load_en`  out  1  one-cycle serializer load strobe
- `buffer_ready`  in  1  serializer is empty and loadable
- `mod_req`  out  1  one-cycle symbol tick to the serializer
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at frame completion
- `err_underrun`  out  1  sticky; cleared by `reset` or an accepted `start`

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, DRAIN, DONE.
- IDLE → on `start`:
  - latch `frame_len`; clear `blk_cnt` and `err_underrun`;
  - go to PREAMBLE when TX_PREAMBLE_EN is defined, else go to PAYLOAD;
  - when `frame_len`==0, PAYLOAD is skipped.
- PREAMBLE:
  - when `buffer_ready` and the guard is clear, drive `cipher_data`=`TX_PREAMBLE` and pulse `load_en`;
  - then go to PAYLOAD, or to DRAIN when `frame_len`==0.
- PAYLOAD:
  - fire condition: `buffer_ready` && `blk_valid` && guard clear;
  - on fire, `cipher_data`←`blk_data` (registered), pulse `load_en` and `blk_ready` in the same cycle, increment `blk_cnt`;
  - when `blk_cnt` reaches `frame_len` → DRAIN.
- Guard: for 2 cycles after any `load_en`, `buffer_ready` is ignored. This covers the serializer's ready-drop latency and prevents a double load.
- Underrun: in PAYLOAD, if `mod_req` fires while `buffer_ready`=1, `blk_valid`=0 and the guard is clear, set `err_underrun`. The state machine keeps waiting; the frame is not aborted.
- DRAIN: wait for `buffer_ready`=1 with the guard clear → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `busy` = (state != IDLE).
- Symbol tick:
  - counter runs only while `busy`; it clears on an accepted `start` and while IDLE;
  - `mod_req` pulses for one cycle when the counter reaches `SYM_DIV`-1, then the counter wraps to 0.
- `abort`:
  - next state is IDLE from any state;
  - `load_en`, `blk_ready`, `mod_req` and `done` are low from the following cycle;
  - `err_underrun` is held;
  - residual serializer contents are not flushed; the system must reset the serializer.
- `start` and `abort` in the same cycle: `abort` wins.
- `blk_cnt` is LEN_W bits and never wraps, because the comparison with `frame_len` stops it.

## Timing
- Reset values: `busy`, `done`, `load_en`, `blk_ready`, `mod_req`, `err_underrun` = 0; `cipher_data` = 0; state = IDLE; all counters = 0.
- `start` → `busy`=1 on the next edge.
- First `load_en`: at the earliest 1 cycle after `busy`, if `buffer_ready`=1.
- `load_en` and `blk_ready` are never high for 2 consecutive cycles.
- First `mod_req`: `SYM_DIV` cycles after `start` is accepted.
- The serializer consumes 64 symbols (64 `mod_req`) per block. Frame duration ≈ (blocks × 64) × `SYM_DIV` cycles.
- `done` is asserted 1 cycle after DRAIN observes `buffer_ready`.

## Configuration
- `TX_PREAMBLE_EN` defined: one preamble block, `TX_PREAMBLE`, precedes the payload; total loads = `frame_len`+1.
- Not defined: the PREAMBLE state and constant are compiled out; total loads = `frame_len`.

## Structure
- Package `z_modem_tx_pkg` holds:
  - `tx_sched_state_t` enum;
  - `TX_PREAMBLE` (128'hAAAA_AAAA_AAAA_AAAA_CCCC_CCCC_3333_3333);
  - `SYMS_PER_BLOCK`=64.
- Sub-module `symbol_tick_gen`: parameter `SYM_DIV`; ports `clk`, `reset`, `en`, `clr`, `tick`. It generates `mod_req`.

## Test plan
- `SYM_DIV`=10, `frame_len`=2, `TX_PREAMBLE_EN` on, `blk_valid` always 1 → 3 `load_en` pulses, first `cipher_data`=`TX_PREAMBLE`; `done` after 192 `mod_req` pulses (±1); `err_underrun`=0.
- Same stimulus with the macro off → 2 loads; `done` after 128 `mod_req` pulses; `cipher_data` equals the supplied blocks in order.
- `frame_len`=0, macro off → `busy` for ≤3 cycles, `done` pulse, no `load_en`.
- `blk_valid` held low for 50 cycles before block 2 (`SYM_DIV`=10) → `err_underrun`=1; `blk_ready` fires once `valid` returns; frame still completes.
- `abort` asserted mid-PAYLOAD → `busy`=0 and `mod_req`=0 on the next cycle, no `done`; a new `start` then runs a full frame.
- `start` pulsed while `busy`, and `start`+`abort` in the same cycle → `frame_len` latch unchanged / state IDLE respectively; `reset` mid-frame → all outputs 0 on the next edge.
